register_file_mp: RTL and testbench

Parametrised multi-port successor to the core integer register file, with configurable width, depth (RV32I 32 / RV32E 16), read and write port counts. It adds:
- same-cycle write-to-read forwarding across all write ports;
- a per-register pending-write scoreboard for the issue stage;
- a software-requested clear sequencer that zeroes the array one register per cycle;
- illegal-address detection in RV32E mode.

It sits between decode/issue (read, scoreboard set) and writeback (write ports).

---
 rtl/register_file_mp.sv | 144 ++++++++++++++
 tb/tb_register_file_mp.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write forwarding, pending-write scoreboard and clear sweep.
// Reads are combinational (zero latency); writes, scoreboard and illegal_addr update on the rising edge.
module register_file_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NRD*5-1:0]       rs_addr,
  output logic [NRD*WIDTH-1:0]   rs_data,
  output logic [NRD-1:0]         rs_busy,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*5-1:0]       wr_addr,
  input  logic [NWR*WIDTH-1:0]   wr_data,
  input  logic                   sb_set,
  input  logic [4:0]             sb_addr,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   illegal_addr
);

  localparam int AW = (DEPTH == 16) ? 4 : 5;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             illegal_q, illegal_d;
  logic [NWR-1:0]   wr_act;

  // In RV32E mode the upper half of the 5-bit address space does not exist.
  function automatic logic legal(input logic [4:0] a);
    return (DEPTH == 32) || !a[4];
  endfunction

  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wr_act[p] = wr_en[p] && legal(wr_addr[5*p +: 5]) &&
                  (wr_addr[5*p +: 5] != 5'd0) && (state_q != SWEEP);
    end
  end

  always_comb begin : read_path
    logic [4:0]       ra;
    logic             hit;
    logic [WIDTH-1:0] fwd;
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rs_addr[5*i +: 5];
      hit = 1'b0;
      fwd = '0;
      // Ascending scan so the highest-index matching port is the one forwarded.
      for (int p = 0; p < NWR; p++) begin
        if (wr_act[p] && (wr_addr[5*p +: 5] == ra)) begin
          hit = 1'b1;
          fwd = wr_data[WIDTH*p +: WIDTH];
        end
      end
      if ((ra != 5'd0) && legal(ra)) begin
        rs_data[WIDTH*i +: WIDTH] = hit ? fwd : regs_q[ra[AW-1:0]];
        rs_busy[i]                = pend_q[ra[AW-1:0]] && !hit;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    regs_d    = regs_q;
    pend_d    = pend_q;
    illegal_d = 1'b0;

    for (int p = 0; p < NWR; p++) begin
      if (wr_act[p]) begin
        regs_d[wr_addr[5*p +: AW]] = wr_data[WIDTH*p +: WIDTH];
        pend_d[wr_addr[5*p +: AW]] = 1'b0;
      end
      if (wr_en[p] && !legal(wr_addr[5*p +: 5])) illegal_d = 1'b1;
    end

    // Applied after the write clears: a newly issued producer keeps the register pending.
    if (sb_set && (state_q != SWEEP) && legal(sb_addr) && (sb_addr != 5'd0)) begin
      pend_d[sb_addr[AW-1:0]] = 1'b1;
    end
    if (sb_set && !legal(sb_addr)) illegal_d = 1'b1;

    for (int i = 0; i < NRD; i++) begin
      if (!legal(rs_addr[5*i +: 5])) illegal_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = SWEEP;
          idx_d   = 5'd1;
        end
      end
      SWEEP: begin
        regs_d[idx_q[AW-1:0]] = '0;
        pend_d[idx_q[AW-1:0]] = 1'b0;
        if (idx_q == 5'(DEPTH - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= 5'd0;
      pend_q    <= '0;
      illegal_q <= 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  assign clear_busy   = (state_q == SWEEP);
  assign clear_done   = (state_q == DONE);
  assign illegal_addr = illegal_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed bench for register_file_mp: RV32I instance against a reference model, RV32E instance for address legality.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  a_rs_addr, b_rs_addr;
  logic [63:0] a_rs_data, b_rs_data;
  logic [1:0]  a_rs_busy, b_rs_busy;
  logic [1:0]  a_wr_en, b_wr_en;
  logic [9:0]  a_wr_addr, b_wr_addr;
  logic [63:0] a_wr_data, b_wr_data;
  logic        a_sb_set, b_sb_set;
  logic [4:0]  a_sb_addr, b_sb_addr;
  logic        a_clear_req, b_clear_req;
  logic        a_clear_busy, b_clear_busy;
  logic        a_clear_done, b_clear_done;
  logic        a_illegal, b_illegal;

  register_file_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .NWR(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr),
    .clear_req(a_clear_req), .clear_busy(a_clear_busy), .clear_done(a_clear_done),
    .illegal_addr(a_illegal)
  );

  register_file_mp #(.WIDTH(32), .DEPTH(16), .NRD(2), .NWR(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr),
    .clear_req(b_clear_req), .clear_busy(b_clear_busy), .clear_done(b_clear_done),
    .illegal_addr(b_illegal)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the RV32I instance: architectural contents, pending flags,
  // and the clear sweep as "cycles left / next register to wipe".
  logic [31:0] m_regs [32];
  logic        m_pend [32];
  int          m_left;
  int          m_pos;
  logic        m_done;

  function automatic logic fwd_hit(input logic [4:0] a);
    logic h = 1'b0;
    if (m_left == 0) begin
      for (int p = 0; p < 2; p++)
        if (a_wr_en[p] && a_wr_addr[5*p +: 5] == a) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [31:0] exp_rd(input int i);
    logic [4:0]  a = a_rs_addr[5*i +: 5];
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_regs[a];
    if (m_left == 0) begin
      for (int p = 0; p < 2; p++)
        if (a_wr_en[p] && a_wr_addr[5*p +: 5] == a) v = a_wr_data[32*p +: 32];
    end
    return v;
  endfunction

  function automatic logic exp_busy(input int i);
    logic [4:0] a = a_rs_addr[5*i +: 5];
    if (a == 5'd0) return 1'b0;
    return m_pend[a] && !fwd_hit(a);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_pend[r] = 1'b0;
    end
    m_left = 0;
    m_pos  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic [4:0] wa;
    logic nd = (m_left == 1);
    if (m_left > 0) begin
      m_regs[m_pos] = 32'd0;
      m_pend[m_pos] = 1'b0;
      m_pos++;
      m_left--;
    end else begin
      for (int p = 0; p < 2; p++) begin
        wa = a_wr_addr[5*p +: 5];
        if (a_wr_en[p] && wa != 5'd0) begin
          m_regs[wa] = a_wr_data[32*p +: 32];
          m_pend[wa] = 1'b0;
        end
      end
      if (a_sb_set && a_sb_addr != 5'd0) m_pend[a_sb_addr] = 1'b1;
      if (a_clear_req && !m_done) begin
        m_left = 31;
        m_pos  = 1;
      end
    end
    m_done = nd;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_en = 2'b00; a_sb_set = 1'b0; a_clear_req = 1'b0;
  endtask

  task automatic b_idle();
    b_wr_en = 2'b00; b_sb_set = 1'b0; b_clear_req = 1'b0;
    b_wr_addr = '0; b_wr_data = '0; b_sb_addr = '0; b_rs_addr = '0;
  endtask

  task automatic test_reset();
    a_rs_addr = {5'd9, 5'd31};
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (a_rs_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", a_rs_data); end
    checks++;
    if (a_rs_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", a_rs_busy); end
    checks++;
    if ({a_clear_busy, a_clear_done, a_illegal, b_illegal} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {a_clear_busy, a_clear_done, a_illegal, b_illegal});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    a_idle();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'd0, 32'hDEADBEEF};
    tick();
    a_wr_en = 2'b00; a_rs_addr = {5'd0, 5'd5}; #1;
    checks++;
    if (a_rs_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_x5 got %h exp deadbeef", a_rs_data[31:0]); end
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'd0, 32'h1234}; a_rs_addr = {5'd0, 5'd0}; #1;
    checks++;
    if (a_rs_data[63:32] !== 32'd0) begin errors++; $display("FAIL x0_fwd got %h exp 0", a_rs_data[63:32]); end
    tick();
    a_wr_en = 2'b00; #1;
    checks++;
    if (a_rs_data[63:32] !== 32'd0) begin errors++; $display("FAIL x0_read got %h exp 0", a_rs_data[63:32]); end
  endtask

  task automatic test_priority();
    a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_data = {32'h22, 32'h11}; a_rs_addr = {5'd7, 5'd0}; #1;
    checks++;
    if (a_rs_data[63:32] !== 32'h22) begin errors++; $display("FAIL prio_fwd got %h exp 22", a_rs_data[63:32]); end
    tick();
    a_wr_en = 2'b00; #1;
    checks++;
    if (a_rs_data[63:32] !== 32'h22) begin errors++; $display("FAIL prio_array got %h exp 22", a_rs_data[63:32]); end
  endtask

  task automatic test_scoreboard();
    a_sb_set = 1'b1; a_sb_addr = 5'd3; a_rs_addr = {5'd0, 5'd3};
    tick();
    a_sb_set = 1'b0; #1;
    checks++;
    if (a_rs_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_busy got %b exp 1", a_rs_busy[0]); end
    a_wr_en = 2'b10; a_wr_addr = {5'd3, 5'd0}; a_wr_data = {32'hABCD0003, 32'd0}; #1;
    checks++;
    if (a_rs_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_fwd_busy got %b exp 0", a_rs_busy[0]); end
    checks++;
    if (a_rs_data[31:0] !== 32'hABCD0003) begin errors++; $display("FAIL sb_fwd_data got %h exp abcd0003", a_rs_data[31:0]); end
    tick();
    a_wr_en = 2'b00; #1;
    checks++;
    if (a_rs_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b exp 0", a_rs_busy[0]); end
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'd0, 32'h33}; a_sb_set = 1'b1; a_sb_addr = 5'd3;
    tick();
    a_wr_en = 2'b00; a_sb_set = 1'b0; #1;
    checks++;
    if (a_rs_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", a_rs_busy[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a_wr_en   = 2'($urandom_range(0, 3));
      a_wr_addr = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      a_wr_data = {$urandom, $urandom};
      a_sb_set  = ($urandom_range(0, 9) < 3);
      a_sb_addr = 5'($urandom_range(0, 9));
      a_rs_addr = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 31))};
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (a_rs_data[32*i +: 32] !== exp_rd(i)) begin
          errors++; $display("FAIL rand_data n=%0d port=%0d got %h exp %h", n, i, a_rs_data[32*i +: 32], exp_rd(i));
        end
        checks++;
        if (a_rs_busy[i] !== exp_busy(i)) begin
          errors++; $display("FAIL rand_busy n=%0d port=%0d got %b exp %b", n, i, a_rs_busy[i], exp_busy(i));
        end
      end
      tick();
      checks++;
      if (a_illegal !== 1'b0) begin errors++; $display("FAIL rand_illegal n=%0d got %b exp 0", n, a_illegal); end
    end
    a_idle();
  endtask

  task automatic fill_regs();
    for (int r = 1; r < 32; r++) begin
      a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'(r)}; a_wr_data = {32'd0, $urandom | 32'h1};
      tick();
    end
    a_wr_en = 2'b00;
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    fill_regs();
    a_clear_req = 1'b1;
    tick();
    a_clear_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      a_wr_en     = (k == 12) ? 2'b01 : 2'b00;
      a_wr_addr   = {5'd0, 5'd2};
      a_wr_data   = {32'd0, 32'h5555AAAA};
      a_clear_req = (k == 5);
      a_rs_addr   = {5'($urandom_range(0, 31)), (k == 12) ? 5'd2 : 5'($urandom_range(0, 31))};
      #1;
      if (a_clear_busy === 1'b1) busy_cnt++;
      if (a_clear_done === 1'b1) done_cnt++;
      checks++;
      if ({a_clear_busy, a_clear_done} !== {m_left > 0, m_done}) begin
        errors++; $display("FAIL clr_state k=%0d got %b exp %b", k, {a_clear_busy, a_clear_done}, {m_left > 0, m_done});
      end
      checks++;
      if (a_rs_data[31:0] !== exp_rd(0)) begin
        errors++; $display("FAIL clr_read k=%0d got %h exp %h", k, a_rs_data[31:0], exp_rd(0));
      end
      tick();
    end
    a_idle();
    checks++;
    if (busy_cnt !== 31) begin errors++; $display("FAIL clr_busy_len got %0d exp 31", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL clr_done_cnt got %0d exp 1", done_cnt); end
    for (int r = 0; r < 32; r++) begin
      a_rs_addr = {5'(r), 5'(r)}; #1;
      checks++;
      if (a_rs_data !== 64'd0) begin errors++; $display("FAIL clr_zero r=%0d got %h exp 0", r, a_rs_data); end
    end
  endtask

  task automatic test_depth16();
    b_idle();
    b_wr_en = 2'b11; b_wr_addr = {5'd1, 5'd4}; b_wr_data = {32'h77, 32'hA5A5A5A5};
    @(posedge clk); #1;
    b_wr_en = 2'b10; b_wr_addr = {5'd20, 5'd0}; b_wr_data = {32'hFFFF0000, 32'd0};
    @(posedge clk); #1;
    b_wr_en = 2'b00; b_rs_addr = {5'd1, 5'd4}; #1;
    checks++;
    if (b_illegal !== 1'b1) begin errors++; $display("FAIL e_wr_illegal got %b exp 1", b_illegal); end
    checks++;
    if (b_rs_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL e_wr_suppressed got %h exp a5a5a5a5", b_rs_data[31:0]); end
    checks++;
    if (b_rs_data[63:32] !== 32'h77) begin errors++; $display("FAIL e_x1 got %h exp 77", b_rs_data[63:32]); end
    @(posedge clk); #1;
    checks++;
    if (b_illegal !== 1'b0) begin errors++; $display("FAIL e_illegal_pulse got %b exp 0", b_illegal); end
    b_rs_addr = {5'd17, 5'd4}; #1;
    checks++;
    if (b_rs_data[63:32] !== 32'd0 || b_rs_busy[1] !== 1'b0) begin
      errors++; $display("FAIL e_rd17 got %h/%b exp 0/0", b_rs_data[63:32], b_rs_busy[1]);
    end
    @(posedge clk); #1;
    b_rs_addr = {5'd1, 5'd4}; #1;
    checks++;
    if (b_illegal !== 1'b1) begin errors++; $display("FAIL e_rd_illegal got %b exp 1", b_illegal); end
  endtask

  task automatic test_reset_mid_sweep();
    int done_cnt = 0;
    fill_regs();
    a_clear_req = 1'b1;
    tick();
    a_clear_req = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    a_rs_addr = {5'd25, 5'd20}; #1;
    checks++;
    if (a_rs_data[31:0] !== m_regs[20] || m_regs[20] == 32'd0) begin
      errors++; $display("FAIL pre_reset_x20 got %h exp %h", a_rs_data[31:0], m_regs[20]);
    end
    reset_n = 1'b0; #1;
    model_reset();
    checks++;
    if (a_rs_data !== 64'd0) begin errors++; $display("FAIL mid_reset_data got %h exp 0", a_rs_data); end
    checks++;
    if ({a_clear_busy, a_clear_done, a_illegal} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_flags got %b exp 000", {a_clear_busy, a_clear_done, a_illegal});
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (a_clear_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL no_done_after_reset got %0d exp 0", done_cnt); end
    a_clear_req = 1'b1;
    tick();
    a_clear_req = 1'b0;
    checks++;
    if (a_clear_busy !== 1'b1) begin errors++; $display("FAIL idle_after_reset got %b exp 1", a_clear_busy); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    a_idle();
    a_wr_addr = '0; a_wr_data = '0; a_sb_addr = '0; a_rs_addr = '0;
    b_idle();
    test_reset();
    test_write_read();
    test_priority();
    test_scoreboard();
    test_random();
    test_clear();
    test_depth16();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
